// File: rtl/uart_word_loader.sv
// Loads a little-endian word count N plus N 32-bit words from UART into memory at BASE_ADDR+4*i, then replies ACK/NAK.
// Each byte costs one request/response handshake; a write issues 1 cycle after its 4th byte; no memory backpressure.
module uart_word_loader #(
  parameter int unsigned            ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned            MAX_WORDS      = 1024,
  parameter int unsigned            TIMEOUT_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded,
  output logic                  uart_rx_enable,
  input  logic                  uart_rx_response,
  input  logic [31:0]           uart_data_recv,
  output logic                  uart_tx_enable,
  input  logic                  uart_tx_response,
  output logic [31:0]           uart_data_send,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_CHECK, S_DATA, S_WRITE, S_ACK, S_NAK, S_FIN_OK, S_FIN_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     shift_q, shift_d;
  logic [31:0]     n_q, n_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [15:0]     wl_q, wl_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rx_en_q, rx_en_d;
  logic            tx_en_q, tx_en_d;
  logic            rx_accept;
  logic            timed_out;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    n_d        = n_q;
    byte_cnt_d = byte_cnt_q;
    wl_d       = wl_q;
    rx_en_d    = 1'b0;
    tx_en_d    = 1'b0;

    rx_accept = ((state_q == S_HDR) || (state_q == S_DATA)) && rx_en_q && uart_rx_response;
    // An empty header may wait forever; only a started header or a data word can time out.
    timed_out = !rx_accept
                && (((state_q == S_HDR) && (byte_cnt_q != 2'd0)) || (state_q == S_DATA))
                && (tmo_q >= TW'(TIMEOUT_CYCLES - 1));

    if (rx_accept || (state_q == S_IDLE)) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          wl_d       = 16'd0;
          byte_cnt_d = 2'd0;
          shift_d    = 32'd0;
        end
      end
      S_HDR, S_DATA: begin
        // Dropping the request for the cycle after a response gives the mandatory idle gap.
        rx_en_d = !rx_accept;
        if (timed_out) begin
          rx_en_d = 1'b0;
          state_d = S_NAK;
        end else if (rx_accept) begin
          shift_d    = {uart_data_recv[7:0], shift_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = (state_q == S_HDR) ? S_CHECK : S_WRITE;
          end
        end
      end
      S_CHECK: begin
        n_d = shift_q;
        if ((shift_q == 32'd0) || (shift_q > 32'(MAX_WORDS))) begin
          state_d = S_NAK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        wl_d    = wl_q + 16'd1;
        state_d = (({16'd0, wl_q} + 32'd1) == n_q) ? S_ACK : S_DATA;
      end
      S_ACK, S_NAK: begin
        tx_en_d = !(tx_en_q && uart_tx_response);
        if (tx_en_q && uart_tx_response) begin
          state_d = (state_q == S_ACK) ? S_FIN_OK : S_FIN_ERR;
        end
      end
      S_FIN_OK, S_FIN_ERR: state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shift_q    <= 32'd0;
      n_q        <= 32'd0;
      byte_cnt_q <= 2'd0;
      wl_q       <= 16'd0;
      tmo_q      <= '0;
      rx_en_q    <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      byte_cnt_q <= byte_cnt_d;
      wl_q       <= wl_d;
      tmo_q      <= tmo_d;
      rx_en_q    <= rx_en_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN_OK);
  assign error          = (state_q == S_FIN_ERR);
  assign words_loaded   = wl_q;
  assign uart_rx_enable = rx_en_q;
  assign uart_tx_enable = tx_en_q;
  // Reply byte is a function of state alone, so it cannot change while tx is requested.
  assign uart_data_send = {24'd0, (state_q == S_ACK) ? 8'h06 : ((state_q == S_NAK) ? 8'h15 : 8'h00)};
  assign mem_write      = (state_q == S_WRITE);
  assign mem_addr       = mem_write ? (BASE_ADDR + (ADDR_WIDTH'(wl_q) << 2)) : '0;
  assign mem_wdata      = mem_write ? shift_q : 32'd0;

endmodule
